// File: rtl/fm_adc_seq_ctrl.sv
// fm_adc_seq_ctrl: FM front-end controller - register decode, ADC channel sequencing
// into frames, receive-mode frame FIFO and scan-mode RSSI accumulation.
module fm_adc_seq_ctrl #(
    parameter int          ADDR_WIDTH = 6,
    parameter int          NUM_CH     = 2,
    parameter int          SAMPLE_W   = 12,
    parameter int          FIFO_DEPTH = 16,
    parameter int          SCAN_LEN   = 256,
    parameter logic [23:0] CHLIST_RST = 24'h000034
) (
    input  logic                         clk,
    input  logic                         RSTn,
    input  logic [ADDR_WIDTH-1:0]        wraddr,
    input  logic [31:0]                  wdata,
    input  logic [3:0]                   wea,
    input  logic [ADDR_WIDTH-1:0]        rdaddr,
    output logic [31:0]                  rdata,
    input  logic                         adc_eoc,
    input  logic [SAMPLE_W-1:0]          adc_data,
    output logic [2:0]                   adc_ch,
    output logic                         adc_pd,
    output logic [3:0]                   hw_state,
    output logic                         frame_valid,
    output logic [NUM_CH*SAMPLE_W-1:0]   frame_data,
    input  logic                         frame_ready,
    output logic                         irq_fifo,
    output logic                         irq_scan
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(SCAN_LEN + 1);
    localparam int SW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'(8'h04);
    localparam logic [ADDR_WIDTH-1:0] A_CHLIST = ADDR_WIDTH'(8'h08);
    localparam logic [ADDR_WIDTH-1:0] A_THRESH = ADDR_WIDTH'(8'h0C);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(8'h10);
    localparam logic [ADDR_WIDTH-1:0] A_RSSI = ADDR_WIDTH'(8'h18);

    typedef enum logic [3:0] {
        IDLE  = 4'b0000,
        RCEV  = 4'b0010,
        SCAN  = 4'b0100,
        SDONE = 4'b1000
    } state_t;

    state_t state, state_n, cmd_state;
    logic wr_ok, cmd_vld, cmd_chg, eoc_ok, last, done, scan_fin, enter_rcev, enter_scan;
    logic [SW-1:0] slot, slot_n;
    logic [SAMPLE_W-1:0] stage [NUM_CH];
    logic [NUM_CH*SAMPLE_W-1:0] frame_w;
    logic [23:0] chlist;
    logic [4:0] thresh;
    logic [7:0] ovf;
    logic [31:0] acc, acc_n, rssi;
    logic [32:0] sum;
    logic [SAMPLE_W-1:0] dev;
    logic [FW-1:0] fcnt;
    logic [NUM_CH*SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr, wptr_n, rptr_n, level, level_n;
    logic push_q, full, pop, push_ok;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_frame
        assign frame_w[k*SAMPLE_W +: SAMPLE_W] = stage[k];
    end

    always_comb begin
        wr_ok = wea == 4'hF;
        cmd_vld = wr_ok && wraddr == A_CTRL && (wdata[7:4] == 4'd1 || wdata[7:4] == 4'd2 ||
                  wdata[15:8] == 8'd1 || wdata[15:8] == 8'd2);
        cmd_state = wdata[7:4] == 4'd1 ? RCEV : wdata[7:4] == 4'd2 ? IDLE :
                    wdata[15:8] == 8'd1 ? SCAN : SDONE;
        cmd_chg = cmd_vld && cmd_state != state;
        // a real mode change swallows any eoc arriving with it, so a half-built frame is dropped
        eoc_ok = adc_eoc && !adc_pd && !cmd_chg;
        last = slot == SW'(NUM_CH - 1);
        done = eoc_ok && last;
        scan_fin = state == SCAN && done && fcnt == FW'(SCAN_LEN - 1);
        state_n = cmd_chg ? cmd_state : scan_fin ? SDONE : state;
        slot_n = state_n != state || done ? '0 : eoc_ok ? slot + SW'(1) : slot;
        enter_rcev = state_n == RCEV && state != RCEV;
        enter_scan = state_n == SCAN && state != SCAN;
        dev = adc_data >= MID ? adc_data - MID : MID - adc_data;
        sum = {1'b0, acc} + 33'(dev);
        acc_n = sum[32] ? '1 : sum[31:0];
    end

    always_comb begin
        level = wptr - rptr;
        full = level == (AW+1)'(FIFO_DEPTH);
        frame_valid = level != '0;
        frame_data = frame_valid ? mem[rptr[AW-1:0]] : '0;
        pop = frame_valid && frame_ready;
        push_ok = push_q && (!full || pop);
        wptr_n = enter_rcev ? '0 : wptr + (AW+1)'(push_ok);
        rptr_n = enter_rcev ? '0 : rptr + (AW+1)'(pop);
        level_n = wptr_n - rptr_n;
    end

    assign hw_state = state;
    assign adc_pd = !(state == RCEV || state == SCAN);

    always_comb
        rdata = rdaddr == A_CTRL   ? {28'b0, state} :
                rdaddr == A_CHLIST ? {8'b0, chlist} :
                rdaddr == A_THRESH ? {27'b0, thresh} :
                rdaddr == A_STATUS ? {16'b0, ovf, 3'b0, 5'(level)} :
                rdaddr == A_RSSI   ? rssi : '0;

    always_ff @(posedge clk or negedge RSTn)
        if (!RSTn) state <= IDLE;
        else state <= state_n;

    always_ff @(posedge clk or negedge RSTn)
        if (!RSTn) begin
            slot <= '0;
            adc_ch <= CHLIST_RST[2:0];
            chlist <= CHLIST_RST;
            thresh <= '0;
            ovf <= '0;
            acc <= '0;
            rssi <= '0;
            fcnt <= '0;
            wptr <= '0;
            rptr <= '0;
            push_q <= 1'b0;
            irq_fifo <= 1'b0;
            irq_scan <= 1'b0;
        end else begin
            slot <= slot_n;
            adc_ch <= chlist[3*slot_n +: 3];
            if (wr_ok && wraddr == A_CHLIST && state == IDLE) chlist <= wdata[23:0];
            if (wr_ok && wraddr == A_THRESH) thresh <= wdata[4:0];
            ovf <= enter_rcev ? '0 : push_q && !push_ok && ovf != 8'hFF ? ovf + 8'd1 : ovf;
            acc <= enter_scan ? '0 : state == SCAN && eoc_ok ? acc_n : acc;
            fcnt <= enter_scan ? '0 : state == SCAN && done ? fcnt + FW'(1) : fcnt;
            if (scan_fin) rssi <= acc_n;
            wptr <= wptr_n;
            rptr <= rptr_n;
            push_q <= done && state == RCEV;
            irq_fifo <= thresh != 5'd0 && 32'(level_n) >= 32'(thresh);
            irq_scan <= scan_fin;
        end

    // sample staging and frame storage carry no reset; validity is tracked by slot and pointers
    always_ff @(posedge clk) begin
        if (eoc_ok) stage[slot] <= adc_data;
        if (push_ok) mem[wptr[AW-1:0]] <= frame_w;
    end
endmodule
